// File: rtl/ksadd_bist_pkg.sv
// Shared types and constants for the ksadd16b BIST controller and its LFSR.
package ksadd_bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } bist_state_t;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_1234;

    localparam logic [15:0] DIR0_K   = 16'hFFFF;
    localparam logic [15:0] DIR0_T   = 16'h0001;
    localparam logic        DIR0_CIN = 1'b0;
    localparam logic [15:0] DIR1_K   = 16'hFFFF;
    localparam logic [15:0] DIR1_T   = 16'hFFFF;
    localparam logic        DIR1_CIN = 1'b1;

    // Right-shifting Galois step; the feedback mask keeps bit 31 set, so a
    // non-zero state can never fall to all-zero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
        logic [31:0] nxt;
        if (cur[0]) begin
            nxt = (cur >> 1) ^ LFSR_POLY;
        end else begin
            nxt = cur >> 1;
        end
        return nxt;
    endfunction

    function automatic logic [31:0] seed_fix(input logic [31:0] seed);
        logic [31:0] res;
        if (seed == 32'h0000_0000) begin
            res = 32'h0000_0001;
        end else begin
            res = seed;
        end
        return res;
    endfunction

endpackage

// File: rtl/ksadd_lfsr32.sv
// 32-bit Galois LFSR supplying pseudo-random operand pairs to the BIST.
module ksadd_lfsr32
    import ksadd_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] state
);

    logic [31:0] state_r;

    // LFSR state: reload on reset/load, otherwise step when asked
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= seed_fix(seed);
        end else if (load) begin
            state_r <= seed_fix(seed);
        end else if (advance) begin
            state_r <= lfsr_step(state_r);
        end else begin
            state_r <= state_r;
        end
    end

    assign state = state_r;

endmodule

// File: rtl/ksadd16b_bist.sv
// BIST controller for the 16-bit Kogge-Stone adder: drives operands, waits for
// the sum to settle, compares against a behavioural sum and logs mismatches.
module ksadd16b_bist
    import ksadd_bist_pkg::*;
#(
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [31:0] LFSR_SEED     = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [16:0] s_i,
    output logic [15:0] k_o,
    output logic [15:0] t_o,
    output logic        cin_o,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] fail_k,
    output logic [15:0] fail_t,
    output logic [16:0] fail_s
);

    localparam logic [15:0] LAST_VEC    = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] SETTLE_INIT = 16'(SETTLE_CYCLES - 1);

    bist_state_t state_r, state_s;
    logic [15:0] vec_cnt_r, vec_cnt_s, settle_cnt_r, settle_cnt_s;
    logic [15:0] k_r, k_s, t_r, t_s;
    logic        cin_r, cin_s;
    logic        busy_r, busy_s, done_r, done_s, pass_r, pass_s;
    logic [15:0] err_r, err_s, fail_k_r, fail_k_s, fail_t_r, fail_t_s;
    logic [16:0] fail_s_r, fail_s_s;
    logic        lfsr_load_s, lfsr_adv_s;
    logic [31:0] lfsr_state_s, lfsr_next_s;
    logic [16:0] expected_s;
    logic        mismatch_s;
    logic [15:0] err_inc_s, vec_next_s;

    ksadd_lfsr32 u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load_s),
        .seed    (LFSR_SEED),
        .advance (lfsr_adv_s),
        .state   (lfsr_state_s)
    );

    // The loaded value is the post-advance state, so look one step ahead.
    assign lfsr_next_s = lfsr_step(lfsr_state_s);
    assign expected_s  = {1'b0, k_r} + {1'b0, t_r} + {16'd0, cin_r};
    assign mismatch_s  = (s_i != expected_s);
    assign err_inc_s   = (err_r == 16'hFFFF) ? err_r : (err_r + 16'd1);
    assign vec_next_s  = vec_cnt_r + 16'd1;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt_r    <= 16'd0;
            settle_cnt_r <= 16'd0;
            k_r          <= 16'd0;
            t_r          <= 16'd0;
            cin_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_r        <= 16'd0;
            fail_k_r     <= 16'd0;
            fail_t_r     <= 16'd0;
            fail_s_r     <= 17'd0;
        end else begin
            vec_cnt_r    <= vec_cnt_s;
            settle_cnt_r <= settle_cnt_s;
            k_r          <= k_s;
            t_r          <= t_s;
            cin_r        <= cin_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            err_r        <= err_s;
            fail_k_r     <= fail_k_s;
            fail_t_r     <= fail_t_s;
            fail_s_r     <= fail_s_s;
        end
    end

    // Next-state and next-value logic
    always_comb begin
        state_s      = state_r;
        vec_cnt_s    = vec_cnt_r;
        settle_cnt_s = settle_cnt_r;
        k_s          = k_r;
        t_s          = t_r;
        cin_s        = cin_r;
        busy_s       = busy_r;
        done_s       = done_r;
        pass_s       = pass_r;
        err_s        = err_r;
        fail_k_s     = fail_k_r;
        fail_t_s     = fail_t_r;
        fail_s_s     = fail_s_r;
        lfsr_load_s  = 1'b0;
        lfsr_adv_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    k_s          = DIR0_K;
                    t_s          = DIR0_T;
                    cin_s        = DIR0_CIN;
                    err_s        = 16'd0;
                    fail_k_s     = 16'd0;
                    fail_t_s     = 16'd0;
                    fail_s_s     = 17'd0;
                    done_s       = 1'b0;
                    pass_s       = 1'b0;
                    busy_s       = 1'b1;
                    vec_cnt_s    = 16'd0;
                    settle_cnt_s = SETTLE_INIT;
                    lfsr_load_s  = 1'b1;
                    state_s      = SETTLE;
                end else begin
                    state_s = state_r;
                end
            end
            SETTLE: begin
                if (settle_cnt_r == 16'd0) begin
                    state_s = CHECK;
                end else begin
                    settle_cnt_s = settle_cnt_r - 16'd1;
                end
            end
            CHECK: begin
                if (mismatch_s) begin
                    err_s = err_inc_s;
                    if (err_r == 16'd0) begin
                        fail_k_s = k_r;
                        fail_t_s = t_r;
                        fail_s_s = s_i;
                    end else begin
                        fail_k_s = fail_k_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (vec_cnt_r == LAST_VEC) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_s == 16'd0);
                end else begin
                    vec_cnt_s    = vec_next_s;
                    settle_cnt_s = SETTLE_INIT;
                    state_s      = SETTLE;
                    if (vec_next_s == 16'd1) begin
                        k_s   = DIR1_K;
                        t_s   = DIR1_T;
                        cin_s = DIR1_CIN;
                    end else begin
                        k_s        = lfsr_next_s[31:16];
                        t_s        = lfsr_next_s[15:0];
                        cin_s      = vec_next_s[0];
                        lfsr_adv_s = 1'b1;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign k_o       = k_r;
    assign t_o       = t_r;
    assign cin_o     = cin_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign err_count = err_r;
    assign fail_k    = fail_k_r;
    assign fail_t    = fail_t_r;
    assign fail_s    = fail_s_r;

endmodule

// File: tb/tb_ksadd16b_bist.sv
// Self-checking bench for ksadd16b_bist: an adder model (optionally faulty) closes
// the loop, and an operand-sequence model built from the vector rules checks it.
module tb_ksadd16b_bist;

    localparam int          NV_A   = 8;
    localparam int          ST_A   = 2;
    localparam logic [31:0] SEED_A = 32'hACE1_1234;
    localparam int          NV_B   = 64;
    localparam int          ST_B   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst_a, start_a, stuck;
    logic [16:0] s_a;
    logic [15:0] k_a, t_a, err_a, fk_a, ft_a;
    logic [16:0] fs_a;
    logic        cin_a, busy_a, done_a, pass_a;

    logic        rst_b, start_b;
    logic [16:0] s_b;
    logic [15:0] k_b, t_b, err_b, fk_b, ft_b;
    logic [16:0] fs_b;
    logic        cin_b, busy_b, done_b, pass_b;

    ksadd16b_bist #(.NUM_VECTORS(NV_A), .SETTLE_CYCLES(ST_A), .LFSR_SEED(SEED_A)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .s_i(s_a),
        .k_o(k_a), .t_o(t_a), .cin_o(cin_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_k(fk_a), .fail_t(ft_a), .fail_s(fs_a)
    );

    ksadd16b_bist #(.NUM_VECTORS(NV_B), .SETTLE_CYCLES(ST_B), .LFSR_SEED(32'h0000_0000)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .s_i(s_b),
        .k_o(k_b), .t_o(t_b), .cin_o(cin_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_k(fk_b), .fail_t(ft_b), .fail_s(fs_b)
    );

    // Adder under test: ideal, or with the carry-out stuck at 0
    always_comb begin
        s_a = {1'b0, k_a} + {1'b0, t_a} + {16'd0, cin_a};
        if (stuck) s_a[16] = 1'b0;
    end
    assign s_b = {1'b0, k_b} + {1'b0, t_b} + {16'd0, cin_b};

    // Multiply the LFSR polynomial state by x^-1 modulo x^32+x^22+x^2+x+1
    function automatic logic [31:0] galois(input logic [31:0] st);
        return st[0] ? ((st >> 1) ^ 32'h8020_0003) : (st >> 1);
    endfunction

    // Operand triple {k,t,cin} of vector idx
    function automatic logic [32:0] model_vec(input logic [31:0] seed, input int idx);
        logic [31:0] st;
        if (idx == 0) return {16'hFFFF, 16'h0001, 1'b0};
        if (idx == 1) return {16'hFFFF, 16'hFFFF, 1'b1};
        st = (seed == 32'd0) ? 32'd1 : seed;
        for (int i = 1; i < idx; i++) st = galois(st);
        return {st, idx[0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full run on dut_a, optionally pulsing start while busy
    task automatic run_a(input bit pulse_mid, input string name);
        logic [32:0] v;
        logic [16:0] truth, seen;
        int          exp_err;
        bit          first;
        logic [48:0] exp_fail;
        int          pulse_vi;
        pulse_vi = int'($urandom_range(1, NV_A - 2));
        exp_err  = 0;
        first    = 1'b0;
        exp_fail = 49'd0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        chk({name, "_clr_err"}, {46'd0, err_a, done_a, pass_a}, 64'd0);
        chk({name, "_clr_fail"}, {15'd0, fk_a, ft_a, fs_a}, 64'd0);
        for (int vi = 0; vi < NV_A; vi++) begin
            v     = model_vec(SEED_A, vi);
            truth = {1'b0, v[32:17]} + {1'b0, v[16:1]} + {16'd0, v[0]};
            seen  = truth;
            if (stuck) seen[16] = 1'b0;
            if (seen != truth) begin
                exp_err++;
                if (!first) begin
                    first    = 1'b1;
                    exp_fail = {v[32:17], v[16:1], seen};
                end
            end
            for (int c = 0; c <= ST_A; c++) begin
                chk($sformatf("%s_v%0d_c%0d", name, vi, c),
                    {29'd0, k_a, t_a, cin_a, busy_a, done_a}, {29'd0, v, 1'b1, 1'b0});
                start_a = (pulse_mid && vi == pulse_vi && c == 0);
                @(posedge clk); #1;
            end
        end
        start_a = 1'b0;
        chk({name, "_done"}, {61'd0, busy_a, done_a, pass_a}, {61'd0, 1'b0, 1'b1, exp_err == 0});
        chk({name, "_err_count"}, {48'd0, err_a}, 64'(exp_err));
        chk({name, "_fail_regs"}, {15'd0, fk_a, ft_a, fs_a}, {15'd0, exp_fail});
        @(posedge clk); #1;
        chk({name, "_done_held"}, {62'd0, done_a, busy_a}, {62'd0, 1'b1, 1'b0});
    endtask

    initial begin
        logic [32:0] v;
        rst_a = 1'b1; start_a = 1'b0; stuck = 1'b0;
        rst_b = 1'b1; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ops",  {29'd0, k_a, t_a, cin_a, busy_a, done_a, pass_a}, 64'd0);
        chk("rst_err",  {48'd0, err_a}, 64'd0);
        chk("rst_fail", {15'd0, fk_a, ft_a, fs_a}, 64'd0);
        rst_a = 1'b0; rst_b = 1'b0;

        run_a(1'b0, "ideal");
        stuck = 1'b1;
        run_a(1'b1, "stuck");
        stuck = 1'b0;
        run_a(1'b0, "rerun");

        // Reset in the second SETTLE, together with a start that must lose
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (ST_A + 2) @(posedge clk);
        #1;
        chk("mid_vec1", {29'd0, k_a, t_a, cin_a, busy_a, done_a},
            {29'd0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0});
        rst_a = 1'b1; start_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0; start_a = 1'b0;
        chk("mid_rst_ops",  {29'd0, k_a, t_a, cin_a, busy_a, done_a, pass_a}, 64'd0);
        chk("mid_rst_err",  {48'd0, err_a}, 64'd0);
        chk("mid_rst_fail", {15'd0, fk_a, ft_a, fs_a}, 64'd0);
        @(posedge clk); #1;
        chk("idle_after_rst", {61'd0, busy_a, done_a, cin_a}, 64'd0);
        run_a(1'b0, "post_rst");

        // Zero seed must behave exactly like seed 1
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int vi = 0; vi < NV_B; vi++) begin
            v = model_vec(32'h0000_0001, vi);
            for (int c = 0; c <= ST_B; c++) begin
                chk($sformatf("seed0_v%0d_c%0d", vi, c),
                    {30'd0, k_b, t_b, cin_b, busy_b}, {30'd0, v, 1'b1});
                if (c == 0) chk($sformatf("seed0_nz%0d", vi), {63'd0, ({k_b, t_b} != 32'd0)}, 64'd1);
                @(posedge clk); #1;
            end
        end
        chk("seed0_done", {46'd0, err_b, busy_b, done_b, pass_b}, {46'd0, 16'd0, 1'b0, 1'b1, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
